// File: rtl/wb_queue_if.sv
// Bus bundle between the execute/memory/decode stages and the writeback queue.
// master: stage side (offers writes, asks about hazards).
// slave : wb_queue side (accepts writes, drives the register-file write port).
// Signals: EX_valid/EX_we/EX_rd/EX_result (ALU offer), M_valid/M_rd/M_data
// (load offer), in_ready, WB_we/WB_rd/WB_data_mem (register-file write),
// D_ra/D_rb with D_ra_pend/D_rb_pend (hazard query), wb_count (occupancy).
interface wb_queue_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned DEPTH     = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                 EX_valid;
    logic                 EX_we;
    logic [ADDR_SIZE-1:0] EX_rd;
    logic [XLEN-1:0]      EX_result;
    logic                 M_valid;
    logic [ADDR_SIZE-1:0] M_rd;
    logic [XLEN-1:0]      M_data;
    logic                 in_ready;
    logic                 WB_we;
    logic [ADDR_SIZE-1:0] WB_rd;
    logic [XLEN-1:0]      WB_data_mem;
    logic [ADDR_SIZE-1:0] D_ra;
    logic [ADDR_SIZE-1:0] D_rb;
    logic                 D_ra_pend;
    logic                 D_rb_pend;
    logic [CW-1:0]        wb_count;

    modport master (
        output EX_valid, EX_we, EX_rd, EX_result,
        output M_valid, M_rd, M_data,
        output D_ra, D_rb,
        input  in_ready, WB_we, WB_rd, WB_data_mem,
        input  D_ra_pend, D_rb_pend, wb_count
    );

    modport slave (
        input  EX_valid, EX_we, EX_rd, EX_result,
        input  M_valid, M_rd, M_data,
        input  D_ra, D_rb,
        output in_ready, WB_we, WB_rd, WB_data_mem,
        output D_ra_pend, D_rb_pend, wb_count
    );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: owns the register file's single write port. Collects ALU
// results and load data into an in-order FIFO (load older than ALU when both
// arrive together) and retires one registered write per cycle. Also reports
// whether a decode source register still has a write in flight.
// Ports: clk, rst_n (async active-low), bus (wb_queue_if.slave).
// Optional feature macro: WB_BYPASS_EN -- when the FIFO is empty, the oldest
// newly accepted entry goes straight to the output register (1-cycle latency).
module wb_queue #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_queue_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] rd;
        logic [XLEN-1:0]      data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          wb_we_q, wb_we_d;
    entry_t        wb_q, wb_d;

    logic          in_ready_c;
    logic          m_acc_c;
    logic          ex_acc_c;
    logic          deq_c;
    logic [1:0]    n_acc_c;
    logic [1:0]    n_enq_c;
    entry_t        first_c, second_c;
    entry_t        slot0_c, slot1_c;
    logic          ra_pend_c, rb_pend_c;

    // Room for two enqueues is always reserved, so any accepted pair fits.
    assign in_ready_c = (count_q <= CW'(DEPTH - 2));
    assign m_acc_c    = bus.M_valid && in_ready_c && (bus.M_rd != '0);
    assign ex_acc_c   = bus.EX_valid && bus.EX_we && in_ready_c && (bus.EX_rd != '0);
    assign deq_c      = (count_q != '0);

    // Next-state: order accepted entries, dequeue head, update pointers.
    always_comb begin
        first_c.rd     = m_acc_c ? bus.M_rd : bus.EX_rd;
        first_c.data   = m_acc_c ? bus.M_data : bus.EX_result;
        second_c.rd    = bus.EX_rd;
        second_c.data  = bus.EX_result;
        n_acc_c        = {1'b0, m_acc_c} + {1'b0, ex_acc_c};
        slot0_c        = first_c;
        slot1_c        = second_c;
        n_enq_c        = n_acc_c;
        wb_we_d        = 1'b0;
        wb_d           = wb_q;
        if (deq_c) begin
            wb_we_d = 1'b1;
            wb_d    = mem_q[head_q];
        end
`ifdef WB_BYPASS_EN
        // Empty FIFO: oldest new entry skips the queue; the other one enqueues.
        else if (n_acc_c != 2'd0) begin
            wb_we_d = 1'b1;
            wb_d    = first_c;
            slot0_c = second_c;
            n_enq_c = n_acc_c - 2'd1;
        end
`endif
        head_d  = head_q + PW'(deq_c);
        tail_d  = tail_q + PW'(n_enq_c);
        count_d = count_q + CW'(n_enq_c) - CW'(deq_c);
    end

    // FIFO storage needs no reset: validity is tracked by head/count.
    always_ff @(posedge clk) begin
        if (n_enq_c != 2'd0) mem_q[tail_q] <= slot0_c;
        if (n_enq_c == 2'd2) mem_q[tail_q + PW'(1)] <= slot1_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wb_we_q <= 1'b0;
            wb_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wb_we_q <= wb_we_d;
            wb_q    <= wb_d;
        end
    end

    // Hazard check over valid FIFO slots plus the output register.
    always_comb begin
        logic [PW-1:0] off;
        ra_pend_c = 1'b0;
        rb_pend_c = 1'b0;
        off       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if (CW'(off) < count_q) begin
                if (mem_q[i].rd == bus.D_ra) ra_pend_c = 1'b1;
                if (mem_q[i].rd == bus.D_rb) rb_pend_c = 1'b1;
            end
        end
        if (wb_we_q && (wb_q.rd == bus.D_ra)) ra_pend_c = 1'b1;
        if (wb_we_q && (wb_q.rd == bus.D_rb)) rb_pend_c = 1'b1;
        if (bus.D_ra == '0) ra_pend_c = 1'b0;
        if (bus.D_rb == '0) rb_pend_c = 1'b0;
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.WB_we       = wb_we_q;
    assign bus.WB_rd       = wb_q.rd;
    assign bus.WB_data_mem = wb_q.data;
    assign bus.D_ra_pend   = ra_pend_c;
    assign bus.D_rb_pend   = rb_pend_c;
    assign bus.wb_count    = count_q;
endmodule

// File: tb/tb_wb_queue.sv
`timescale 1ns/1ps
module tb_wb_queue;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_queue_if #(.XLEN(XLEN), .ADDR_SIZE(AW), .DEPTH(DEPTH)) bus ();

    wb_queue #(.XLEN(XLEN), .ADDR_SIZE(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.EX_valid  = 1'b0;
        bus.EX_we     = 1'b0;
        bus.EX_rd     = '0;
        bus.EX_result = '0;
        bus.M_valid   = 1'b0;
        bus.M_rd      = '0;
        bus.M_data    = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.D_ra = 5'd1;
        bus.D_rb = 5'd2;
        #2;
        if (bus.WB_we !== 1'b0) begin $display("FAIL reset_we got %0b exp 0", bus.WB_we); n_fail++; end
        n_cmp++;
        if (bus.WB_rd !== 5'd0) begin $display("FAIL reset_rd got %0d exp 0", bus.WB_rd); n_fail++; end
        n_cmp++;
        if (bus.WB_data_mem !== 32'd0) begin $display("FAIL reset_data got %0h exp 0", bus.WB_data_mem); n_fail++; end
        n_cmp++;
        if (bus.wb_count !== 3'd0) begin $display("FAIL reset_count got %0d exp 0", bus.wb_count); n_fail++; end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin $display("FAIL reset_ready got %0b exp 1", bus.in_ready); n_fail++; end
        n_cmp++;
        if ({bus.D_ra_pend, bus.D_rb_pend} !== 2'b00) begin
            $display("FAIL reset_pend got %b exp 00", {bus.D_ra_pend, bus.D_rb_pend}); n_fail++;
        end
        n_cmp++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_ex();
        int lat = 0;
        bus.EX_valid = 1'b1; bus.EX_we = 1'b1; bus.EX_rd = 5'd5; bus.EX_result = 32'h1234;
        for (int k = 1; k <= 4; k++) begin
            step();
            idle();
            if (bus.WB_we === 1'b1) begin lat = k; break; end
        end
        if (lat != LAT) begin $display("FAIL single_latency got %0d exp %0d", lat, LAT); n_fail++; end
        n_cmp++;
        if (bus.WB_rd !== 5'd5) begin $display("FAIL single_rd got %0d exp 5", bus.WB_rd); n_fail++; end
        n_cmp++;
        if (bus.WB_data_mem !== 32'h1234) begin $display("FAIL single_data got %0h exp 1234", bus.WB_data_mem); n_fail++; end
        n_cmp++;
        step();
        if (bus.WB_we !== 1'b0) begin $display("FAIL single_one_cycle got %0b exp 0", bus.WB_we); n_fail++; end
        n_cmp++;
        if (bus.wb_count !== 3'd0) begin $display("FAIL single_count got %0d exp 0", bus.wb_count); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_simultaneous();
        int lat = 0;
        bus.M_valid = 1'b1; bus.M_rd = 5'd3; bus.M_data = 32'hAA;
        bus.EX_valid = 1'b1; bus.EX_we = 1'b1; bus.EX_rd = 5'd4; bus.EX_result = 32'hBB;
        for (int k = 1; k <= 4; k++) begin
            step();
            idle();
            if (bus.WB_we === 1'b1) begin lat = k; break; end
        end
        if (lat != LAT) begin $display("FAIL simul_latency got %0d exp %0d", lat, LAT); n_fail++; end
        n_cmp++;
        if ({bus.WB_rd, bus.WB_data_mem} !== {5'd3, 32'hAA}) begin
            $display("FAIL simul_first got r%0d=%0h exp r3=aa", bus.WB_rd, bus.WB_data_mem); n_fail++;
        end
        n_cmp++;
        step();
        if ({bus.WB_we, bus.WB_rd, bus.WB_data_mem} !== {1'b1, 5'd4, 32'hBB}) begin
            $display("FAIL simul_second got we=%0b r%0d=%0h exp we=1 r4=bb", bus.WB_we, bus.WB_rd, bus.WB_data_mem); n_fail++;
        end
        n_cmp++;
        step();
        if (bus.WB_we !== 1'b0) begin $display("FAIL simul_end got %0b exp 0", bus.WB_we); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_full_wrap();
        logic [AW-1:0] exp_seq [$];
        logic          exp_rdy [4];
        logic [2:0]    exp_cnt [4];
        logic [AW-1:0] got_rd  [$];
        logic [31:0]   got_dat [$];
        logic [AW-1:0] r;
`ifdef WB_BYPASS_EN
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd2};
        exp_seq = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
`else
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_cnt = '{3'd2, 3'd3, 3'd2, 3'd3};
        exp_seq = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd16, 5'd17};
`endif
        for (int c = 0; c < 4; c++) begin
            bus.M_valid = 1'b1; bus.M_rd = 5'(10 + 2 * c); bus.M_data = 32'hD000_0000 | 32'(10 + 2 * c);
            bus.EX_valid = 1'b1; bus.EX_we = 1'b1; bus.EX_rd = 5'(11 + 2 * c);
            bus.EX_result = 32'hD000_0000 | 32'(11 + 2 * c);
            if (bus.in_ready !== exp_rdy[c]) begin
                $display("FAIL full_ready[%0d] got %0b exp %0b", c, bus.in_ready, exp_rdy[c]); n_fail++;
            end
            n_cmp++;
            step();
            if (bus.WB_we === 1'b1) begin got_rd.push_back(bus.WB_rd); got_dat.push_back(bus.WB_data_mem); end
            if (bus.wb_count !== exp_cnt[c]) begin
                $display("FAIL full_count[%0d] got %0d exp %0d", c, bus.wb_count, exp_cnt[c]); n_fail++;
            end
            n_cmp++;
        end
        idle();
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.WB_we === 1'b1) begin got_rd.push_back(bus.WB_rd); got_dat.push_back(bus.WB_data_mem); end
        end
        if (got_rd.size() != exp_seq.size()) begin
            $display("FAIL full_drain_count got %0d exp %0d", got_rd.size(), exp_seq.size()); n_fail++;
        end
        n_cmp++;
        for (int i = 0; i < exp_seq.size() && i < got_rd.size(); i++) begin
            r = exp_seq[i];
            if ({got_rd[i], got_dat[i]} !== {r, 32'hD000_0000 | 32'(r)}) begin
                $display("FAIL full_order[%0d] got r%0d=%0h exp r%0d=%0h", i, got_rd[i], got_dat[i], r, 32'hD000_0000 | 32'(r));
                n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_drop();
        bus.EX_valid = 1'b1; bus.EX_we = 1'b1; bus.EX_rd = 5'd0; bus.EX_result = 32'hFF;
        bus.M_valid = 1'b1; bus.M_rd = 5'd0; bus.M_data = 32'hEE;
        step();
        if ({bus.wb_count, bus.WB_we} !== {3'd0, 1'b0}) begin
            $display("FAIL drop_rd0 got count=%0d we=%0b exp 0 0", bus.wb_count, bus.WB_we); n_fail++;
        end
        n_cmp++;
        idle();
        bus.EX_valid = 1'b1; bus.EX_we = 1'b0; bus.EX_rd = 5'd7; bus.EX_result = 32'h77;
        step();
        if ({bus.wb_count, bus.WB_we} !== {3'd0, 1'b0}) begin
            $display("FAIL drop_we0 got count=%0d we=%0b exp 0 0", bus.wb_count, bus.WB_we); n_fail++;
        end
        n_cmp++;
        idle();
        step();
        if ({bus.wb_count, bus.WB_we} !== {3'd0, 1'b0}) begin
            $display("FAIL drop_after got count=%0d we=%0b exp 0 0", bus.wb_count, bus.WB_we); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_hazard();
        bit seen = 1'b0;
        bus.D_ra = 5'd9;
        bus.D_rb = 5'd10;
        #1;
        if ({bus.D_ra_pend, bus.D_rb_pend} !== 2'b00) begin
            $display("FAIL haz_before got %b exp 00", {bus.D_ra_pend, bus.D_rb_pend}); n_fail++;
        end
        n_cmp++;
        bus.EX_valid = 1'b1; bus.EX_we = 1'b1; bus.EX_rd = 5'd9; bus.EX_result = 32'h99;
        for (int k = 1; k <= 4; k++) begin
            step();
            idle();
            if ({bus.D_ra_pend, bus.D_rb_pend} !== 2'b10) begin
                $display("FAIL haz_pending[%0d] got %b exp 10", k, {bus.D_ra_pend, bus.D_rb_pend}); n_fail++;
            end
            n_cmp++;
            if (bus.WB_we === 1'b1) begin seen = 1'b1; break; end
        end
        if (seen !== 1'b1) begin $display("FAIL haz_write_seen got 0 exp 1"); n_fail++; end
        n_cmp++;
        step();
        if ({bus.D_ra_pend, bus.D_rb_pend} !== 2'b00) begin
            $display("FAIL haz_cleared got %b exp 00", {bus.D_ra_pend, bus.D_rb_pend}); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_drain();
`ifdef WB_BYPASS_EN
        logic [2:0] exp_c = 3'd1;
`else
        logic [2:0] exp_c = 3'd2;
`endif
        bus.D_ra = 5'd21;
        bus.D_rb = 5'd0;
        bus.M_valid = 1'b1; bus.M_rd = 5'd20; bus.M_data = 32'h20;
        bus.EX_valid = 1'b1; bus.EX_we = 1'b1; bus.EX_rd = 5'd21; bus.EX_result = 32'h21;
        step();
        bus.M_valid = 1'b0;
        bus.EX_rd = 5'd22; bus.EX_result = 32'h22;
        step();
        idle();
        if ({bus.WB_we, bus.wb_count, bus.D_ra_pend} !== {1'b1, exp_c, 1'b1}) begin
            $display("FAIL rst_pre got we=%0b count=%0d pend=%0b exp 1 %0d 1", bus.WB_we, bus.wb_count, bus.D_ra_pend, exp_c);
            n_fail++;
        end
        n_cmp++;
        #2 rst_n = 1'b0;
        #1;
        if ({bus.WB_we, bus.WB_rd, bus.WB_data_mem} !== {1'b0, 5'd0, 32'd0}) begin
            $display("FAIL rst_wb got we=%0b rd=%0d data=%0h exp 0 0 0", bus.WB_we, bus.WB_rd, bus.WB_data_mem); n_fail++;
        end
        n_cmp++;
        if ({bus.wb_count, bus.in_ready, bus.D_ra_pend} !== {3'd0, 1'b1, 1'b0}) begin
            $display("FAIL rst_state got count=%0d ready=%0b pend=%0b exp 0 1 0", bus.wb_count, bus.in_ready, bus.D_ra_pend);
            n_fail++;
        end
        n_cmp++;
        step();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if ({bus.WB_we, bus.wb_count} !== {1'b0, 3'd0}) begin
                $display("FAIL rst_after[%0d] got we=%0b count=%0d exp 0 0", k, bus.WB_we, bus.wb_count); n_fail++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_ex();
        test_simultaneous();
        test_full_wrap();
        test_drop();
        test_hazard();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
